// File: rtl/block_text_emitter_if.sv
// Command/character handshake bundle for block_text_emitter.
// master drives cmd_valid/cmd_op/out_ready; slave drives the rest.
interface block_text_emitter_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] depth;
  logic       balanced;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, out_ready,
    input  cmd_ready, out, out_valid,
    input  depth, balanced, err
  );

  modport slave (
    input  cmd_valid, cmd_op, out_ready,
    output cmd_ready, out, out_valid,
    output depth, balanced, err
  );
endinterface

// File: rtl/block_text_emitter.sv
// Emits "begin "/"end "/" " text per command, tracks block nesting depth.
// Ports: clk, reset (async active-low), bus (slave: cmd, out, depth, err).
// Option BLOCK_TEXT_CASE_MIX_EN: alternate letter case across taken letters.
module block_text_emitter (
  input  logic                 clk,
  input  logic                 reset,
  block_text_emitter_if.slave  bus
);

  localparam logic [1:0] OP_BEGIN = 2'b00;
  localparam logic [1:0] OP_END   = 2'b01;
  localparam logic [1:0] OP_FLUSH = 2'b10;
  localparam logic [1:0] OP_SPACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FLUSH
  } state_t;

  state_t     state;
  logic [1:0] word;
  logic [2:0] idx;
  logic [3:0] depth_q;
  logic       err_q;
  logic       take;
  logic       letter;
  logic [2:0] last;
  logic [7:0] ch;
  logic [7:0] ch_out;

  always_comb begin
    ch = 8'h20;
    unique case (word)
      OP_BEGIN: begin
        unique case (idx)
          3'd0:    ch = "b";
          3'd1:    ch = "e";
          3'd2:    ch = "g";
          3'd3:    ch = "i";
          3'd4:    ch = "n";
          default: ch = 8'h20;
        endcase
      end
      OP_END: begin
        unique case (idx)
          3'd0:    ch = "e";
          3'd1:    ch = "n";
          3'd2:    ch = "d";
          default: ch = 8'h20;
        endcase
      end
      default: ch = 8'h20;
    endcase
  end

  always_comb begin
    last = 3'd0;
    unique case (word)
      OP_BEGIN: last = 3'd5;
      OP_END:   last = 3'd3;
      default:  last = 3'd0;
    endcase
  end

  assign letter = (ch != 8'h20);
  assign take   = bus.out_valid && bus.out_ready;

`ifdef BLOCK_TEXT_CASE_MIX_EN
  logic tgl;
  assign ch_out = (tgl && letter) ? (ch - 8'h20) : ch;
`else
  assign ch_out = ch;
`endif

  assign bus.out_valid = (state != IDLE);
  assign bus.out       = bus.out_valid ? ch_out : 8'h20;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.depth     = depth_q;
  assign bus.balanced  = (depth_q == 4'd0);
  assign bus.err       = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      word    <= OP_SPACE;
      idx     <= 3'd0;
      depth_q <= 4'd0;
      err_q   <= 1'b0;
`ifdef BLOCK_TEXT_CASE_MIX_EN
      tgl     <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
`ifdef BLOCK_TEXT_CASE_MIX_EN
      if (take && letter) tgl <= ~tgl;
`endif
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            unique case (bus.cmd_op)
              OP_BEGIN: begin
                if (depth_q == 4'd15) begin
                  err_q <= 1'b1;
                end else begin
                  depth_q <= depth_q + 4'd1;
                  word    <= OP_BEGIN;
                  idx     <= 3'd0;
                  state   <= EMIT;
                end
              end
              OP_END: begin
                if (depth_q == 4'd0) begin
                  err_q <= 1'b1;
                end else begin
                  depth_q <= depth_q - 4'd1;
                  word    <= OP_END;
                  idx     <= 3'd0;
                  state   <= EMIT;
                end
              end
              OP_SPACE: begin
                word  <= OP_SPACE;
                idx   <= 3'd0;
                state <= EMIT;
              end
              default: begin
                // FLUSH on an empty stack is a silent no-op
                if (depth_q != 4'd0) begin
                  word  <= OP_END;
                  idx   <= 3'd0;
                  state <= FLUSH;
                end
              end
            endcase
          end
        end
        EMIT: begin
          if (take) begin
            if (idx == last) begin
              idx   <= 3'd0;
              state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        FLUSH: begin
          if (take) begin
            if (idx == 3'd3) begin
              // one block closes per completed "end "
              idx     <= 3'd0;
              depth_q <= depth_q - 4'd1;
              if (depth_q == 4'd1) state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_text_emitter.sv
// Directed self-checking bench for block_text_emitter.
// Drives and samples on the falling clock edge.
module tb_block_text_emitter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   tgl;

  block_text_emitter_if ifc ();

  block_text_emitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [7:0] c);
    logic [7:0] r;
    r = c;
`ifdef BLOCK_TEXT_CASE_MIX_EN
    if (c != 8'h20) begin
      if (tgl) r = c - 8'h20;
      tgl = ~tgl;
    end
`endif
    return r;
  endfunction

  task automatic apply_reset();
    ifc.cmd_valid = 1'b0;
    ifc.out_ready = 1'b1;
    reset = 1'b0;
    tgl = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op);
    int t;
    t = 0;
    while (ifc.cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL issue_timeout: cmd_ready=%b want 1", ifc.cmd_ready);
    end
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op = op;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = ~op;
  endtask

  task automatic take_char(input string name, input logic [7:0] c);
    logic [7:0] e;
    e = model(c);
    ifc.out_ready = 1'b1;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out !== e) begin
      errors++;
      $display("FAIL %s: got valid=%b out=%h, want valid=1 out=%h",
               name, ifc.out_valid, ifc.out, e);
    end
    @(negedge clk);
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out !== 8'h20 ||
        ifc.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: got valid=%b out=%h rdy=%b, want 0 20 1",
               name, ifc.out_valid, ifc.out, ifc.cmd_ready);
    end
  endtask

  task automatic expect_text(input string name, input string s);
    for (int i = 0; i < s.len(); i++) take_char(name, s[i]);
    expect_idle(name);
  endtask

  task automatic check_depth(input string name, input logic [3:0] d);
    checks++;
    if (ifc.depth !== d || ifc.balanced !== (d == 4'd0)) begin
      errors++;
      $display("FAIL %s: got depth=%0d bal=%b, want depth=%0d bal=%b",
               name, ifc.depth, ifc.balanced, d, (d == 4'd0));
    end
  endtask

  task automatic check_err(input string name, input logic e);
    checks++;
    if (ifc.err !== e) begin
      errors++;
      $display("FAIL %s: got err=%b want %b", name, ifc.err, e);
    end
  endtask

  task automatic test_reset();
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 2'b00;
    ifc.out_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    tgl = 1'b0;
    #1;
    expect_idle("reset");
    check_depth("reset_depth", 4'd0);
    check_err("reset_err", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("reset_release");
  endtask

  task automatic test_begin();
    issue(2'b00);
    check_depth("begin_depth", 4'd1);
    expect_text("begin_word", "begin ");
    check_depth("begin_depth_after", 4'd1);
  endtask

  task automatic test_flush();
    apply_reset();
    issue(2'b00);
    expect_text("flush_b1", "begin ");
    issue(2'b00);
    expect_text("flush_b2", "begin ");
    check_depth("flush_depth2", 4'd2);
    issue(2'b10);
    take_char("flush_e1", "e");
    take_char("flush_n1", "n");
    take_char("flush_d1", "d");
    take_char("flush_s1", " ");
    check_depth("flush_mid_depth", 4'd1);
    expect_text("flush_e2", "end ");
    check_depth("flush_depth0", 4'd0);
  endtask

  task automatic test_end_reject();
    apply_reset();
    issue(2'b01);
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL endrej_valid: got %b want 0", ifc.out_valid);
    end
    check_err("endrej_err", 1'b1);
    check_depth("endrej_depth", 4'd0);
    expect_idle("endrej");
    @(negedge clk);
    check_err("endrej_err_clear", 1'b0);
  endtask

  task automatic test_flush_empty();
    apply_reset();
    issue(2'b10);
    expect_idle("flush_empty");
    check_err("flush_empty_err", 1'b0);
    check_depth("flush_empty_depth", 4'd0);
  endtask

  task automatic test_stall();
    logic [7:0] e;
    apply_reset();
    issue(2'b00);
    take_char("stall_b", "b");
    ifc.out_ready = 1'b0;
    e = model("e");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out !== e) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b out=%h, want 1 %h",
                 k, ifc.out_valid, ifc.out, e);
      end
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out !== e) begin
      errors++;
      $display("FAIL stall_resume: got valid=%b out=%h, want 1 %h",
               ifc.out_valid, ifc.out, e);
    end
    @(negedge clk);
    expect_text("stall_rest", "gin ");
  endtask

  task automatic test_reset_midword();
    apply_reset();
    issue(2'b00);
    take_char("mid_b", "b");
    take_char("mid_e", "e");
    reset = 1'b0;
    tgl = 1'b0;
    #1;
    expect_idle("mid_reset");
    check_depth("mid_reset_depth", 4'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_idle("mid_release");
    issue(2'b00);
    expect_text("mid_again", "begin ");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    issue(2'b00);
    expect_text("b2b_begin", "begin ");
    issue(2'b11);
    expect_text("b2b_space", " ");
    issue(2'b01);
    check_depth("b2b_end_depth", 4'd0);
    expect_text("b2b_end", "end ");
  endtask

  task automatic test_overflow();
    string s;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      issue(2'b00);
      expect_text("ovf_begin", "begin ");
    end
    check_depth("ovf_depth15", 4'd15);
    issue(2'b00);
    check_err("ovf_err", 1'b1);
    expect_idle("ovf_reject");
    check_depth("ovf_depth_hold", 4'd15);
    @(negedge clk);
    check_err("ovf_err_clear", 1'b0);
    s = "";
    for (int i = 0; i < 15; i++) s = {s, "end "};
    issue(2'b10);
    expect_text("ovf_flush", s);
    check_depth("ovf_flush_depth", 4'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tgl = 1'b0;
    test_reset();
    test_begin();
    test_flush();
    test_end_reject();
    test_flush_empty();
    test_stall();
    test_reset_midword();
    test_back_to_back();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
